// File: rtl/alu_scheduler.sv
// Round-robin arbiter that shares one combinational ALU among NREQ valid/ready requesters
// and returns each result on a single response channel tagged with the requester id.
module alu_scheduler #(
    parameter int bits = 4,
    parameter int NREQ = 3,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [bits*NREQ-1:0] req_a,
    input  logic [bits*NREQ-1:0] req_b,
    output logic [bits-1:0]      alu_a,
    output logic [bits-1:0]      alu_b,
    output logic [bits-1:0]      alu_c,
    output logic [3:0]           alu_control,
    input  logic [bits-1:0]      alu_result,
    input  logic [3:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [bits-1:0]      rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err
);

    // state | meaning
    // IDLE  | waiting for a request; grant offered combinationally
    // EXEC  | latched operands on the ALU; result captured at the edge
    // RESP  | response held on rsp_* until rsp_valid & rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr_nxt;
    logic           gnt_any;
    logic [3:0]     sel_op;
    logic [bits-1:0] sel_a;
    logic [bits-1:0] sel_b;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1111, 4'b0001: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    endfunction

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        gnt_any = |req_valid;
        gnt_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[i]) gnt_id = IDW'(i);
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[i] && (IDW'(i) >= ptr)) gnt_id = IDW'(i);
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_id) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[bits*i +: bits];
                sel_b  = req_b[bits*i +: bits];
            end
        end
    end

    assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    assign alu_c   = '0;

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_any) req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        alu_control <= sel_op;
                        rsp_id      <= gnt_id;
                        ptr         <= ptr_nxt;
                        if (op_legal(sel_op)) begin
                            state <= EXEC;
                        end else begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: a bench-side ALU, a transaction-level model checked
// every cycle, and literal expectations for each directed scenario.
module tb_alu_scheduler;

    localparam int BITS = 4;
    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [BITS*NREQ-1:0] req_a;
    logic [BITS*NREQ-1:0] req_b;
    logic [BITS-1:0]      alu_a, alu_b, alu_c, alu_result;
    logic [3:0]           alu_control, alu_flags;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_result;
    logic [3:0]           rsp_flags;

    int n_vec = 0;
    int n_err = 0;

    alu_scheduler #(.bits(BITS), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {flags N,Z,C,V, result}; C on SUB is the borrow out.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0100: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                           v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'b0010: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                           v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'b0000: r = a & b;
            4'b1100: r = a | b;
            4'b1111: r = ~b;
            4'b0001: r = a ^ b;
            default: r = '0;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1111, 4'b0001};
    endfunction

    assign {alu_flags, alu_result} = alu_f(alu_control, alu_a, alu_b);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, ready only when nothing is held.
    bit         m_have;
    int         m_cnt;
    int         m_ptr;
    int         m_g;
    int         m_id;
    logic [3:0] m_res, m_flg;
    logic       m_err;
    logic [3:0] m_a, m_b, m_op;
    logic [NREQ-1:0] m_ready;

    always @(negedge clk) begin : model
        if (!rst_n) begin
            m_have = 0; m_cnt = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_op = '0;
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_fields", {21'd0, rsp_err, rsp_flags, rsp_result, rsp_id}, 0);
            check("rst_alu_drive", {16'd0, alu_control, alu_c, alu_b, alu_a}, 0);
        end else begin
            m_g = -1;
            if (!m_have)
                for (int k = 0; k < NREQ; k++)
                    if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            m_ready = '0;
            if (m_g >= 0) m_ready[m_g] = 1'b1;
            check("mdl_req_ready", 32'(req_ready), 32'(m_ready));
            check("mdl_rsp_valid", 32'(rsp_valid), 32'(m_have && m_cnt == 0));
            if (m_have && m_cnt == 0) begin
                check("mdl_rsp_id", 32'(rsp_id), 32'(m_id));
                check("mdl_rsp_result", 32'(rsp_result), 32'(m_res));
                check("mdl_rsp_flags", 32'(rsp_flags), 32'(m_flg));
                check("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
            end
            check("mdl_alu_drive", {16'd0, alu_control, alu_c, alu_b, alu_a},
                  {16'd0, m_op, 4'd0, m_b, m_a});
            if (m_have) begin
                if (m_cnt > 0) m_cnt--;
                else if (rsp_ready) m_have = 0;
            end else if (m_g >= 0) begin
                m_have = 1;
                m_id   = m_g;
                m_op   = req_op[4*m_g +: 4];
                m_a    = req_a[4*m_g +: 4];
                m_b    = req_b[4*m_g +: 4];
                if (is_legal(m_op)) begin
                    {m_flg, m_res} = alu_f(m_op, m_a, m_b);
                    m_err = 1'b0;
                    m_cnt = 1;
                end else begin
                    m_flg = '0; m_res = '0; m_err = 1'b1;
                    m_cnt = 0;
                end
                m_ptr = (m_g + 1) % NREQ;
            end
        end
    end

    task automatic drive(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]    = 1'b1;
        req_op[4*i +: 4] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    // Returns just after the accept edge, with the granted requester dropped.
    task automatic wait_grant(input string nm, input int exp_id);
        logic [NREQ-1:0] got;
        int k;
        got = '0;
        k = 0;
        while (got == '0 && k < 20) begin
            @(negedge clk);
            got = req_ready;
            k++;
        end
        check(nm, 32'(got), 32'(1) << exp_id);
        @(posedge clk);
        #1 req_valid = req_valid & ~got;
    endtask

    task automatic expect_rsp(input string nm, input int lat, input int id,
                              input logic [3:0] res, input logic [3:0] flg, input logic err);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 10);
        check({nm, "_latency"}, 32'(k), 32'(lat));
        check({nm, "_id"}, 32'(rsp_id), 32'(id));
        check({nm, "_result"}, 32'(rsp_result), 32'(res));
        check({nm, "_flags"}, 32'(rsp_flags), 32'(flg));
        check({nm, "_err"}, 32'(rsp_err), 32'(err));
    endtask

    initial begin : stim
        rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1 single ADD
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive(0, 4'b0100, 4'b0001, 4'b1110);
        wait_grant("t1_grant", 0);
        expect_rsp("t1", 2, 0, 4'b1111, 4'b1000, 1'b0);

        // T2 signed overflow
        @(posedge clk); #1 drive(1, 4'b0100, 4'b0100, 4'b0101);
        wait_grant("t2_grant", 1);
        expect_rsp("t2", 2, 1, 4'b1001, 4'b1001, 1'b0);

        // Lone req2 AND moves the pointer back to 0
        @(posedge clk); #1 drive(2, 4'b0000, 4'b1010, 4'b0110);
        wait_grant("fill_grant", 2);
        expect_rsp("fill", 2, 2, 4'b0010, 4'b0000, 1'b0);

        // T3 round-robin with all three valid
        @(posedge clk); #1;
        drive(0, 4'b0010, 4'b0111, 4'b0010);
        drive(1, 4'b0001, 4'b1001, 4'b0101);
        drive(2, 4'b1100, 4'b0011, 4'b0011);
        wait_grant("t3_grant0", 0);
        expect_rsp("t3_sub", 2, 0, 4'b0101, 4'b0000, 1'b0);
        wait_grant("t3_grant1", 1);
        expect_rsp("t3_xor", 2, 1, 4'b1100, 4'b1000, 1'b0);
        wait_grant("t3_grant2", 2);
        expect_rsp("t3_or", 2, 2, 4'b0011, 4'b0000, 1'b0);
        @(posedge clk); #1;
        drive(0, 4'b0100, 4'b0001, 4'b0001);
        drive(1, 4'b0100, 4'b0010, 4'b0010);
        drive(2, 4'b0100, 4'b0011, 4'b0011);
        wait_grant("t3_wrap_grant", 0);
        req_valid = '0;
        expect_rsp("t3_wrap", 2, 0, 4'b0010, 4'b0000, 1'b0);

        // T4 illegal op under backpressure, with req0 waiting
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(2, 4'b1010, 4'b0101, 4'b0011);
        wait_grant("t4_grant", 2);
        expect_rsp("t4", 1, 2, 4'b0000, 4'b0000, 1'b1);
        @(posedge clk); #1 drive(0, 4'b0100, 4'b0011, 4'b0001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 1);
            check("t4_hold_rsp", {21'd0, rsp_err, rsp_flags, rsp_result, rsp_id}, {21'd0, 1'b1, 8'h00, 2'd2});
            check("t4_hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        wait_grant("t4_after_grant", 0);
        expect_rsp("t4_after", 2, 0, 4'b0100, 4'b0000, 1'b0);

        // T5 reset during EXEC
        @(posedge clk); #1 drive(1, 4'b1111, 4'b0000, 4'b1001);
        wait_grant("t5_grant", 1);
        check("t5_exec_drive", {24'd0, alu_control, alu_b}, {24'd0, 4'b1111, 4'b1001});
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(req_ready), 0);
        check("t5_rst_valid", 32'(rsp_valid), 0);
        check("t5_rst_alu", {16'd0, alu_control, alu_c, alu_b, alu_a}, 0);
        check("t5_rst_rsp", {21'd0, rsp_err, rsp_flags, rsp_result, rsp_id}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        drive(1, 4'b0100, 4'b0010, 4'b0011);
        drive(2, 4'b0001, 4'b1111, 4'b0101);
        wait_grant("t5_ptr0_grant", 1);
        expect_rsp("t5_add", 2, 1, 4'b0101, 4'b0000, 1'b0);
        wait_grant("t5_next_grant", 2);
        expect_rsp("t5_xor", 2, 2, 4'b1010, 4'b1000, 1'b0);

        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
